// File: rtl/pkt_mem_responder_pkg.sv
// Shared encodings for the packet-memory read interface: transfer sizes,
// buffer ownership states and the request byte-count helper.
package pkt_mem_responder_pkg;

    typedef enum logic [1:0] {
        SZ_W   = 2'd0,
        SZ_H   = 2'd1,
        SZ_B   = 2'd2,
        SZ_RSV = 2'd3
    } xfer_sz_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FILL  = 2'd1,
        ST_READY = 2'd2
    } buf_state_e;

    // Reserved size reports zero bytes; callers flag it as illegal separately.
    function automatic logic [2:0] xfer_bytes(input logic [1:0] sz);
        case (sz)
            SZ_W:    return 3'd4;
            SZ_H:    return 3'd2;
            SZ_B:    return 3'd1;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/pkt_bank_ram.sv
// One bank of packet storage: single write port, registered read port.
// A read and write to the same word in one cycle returns the old contents.
module pkt_bank_ram #(
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [31:0]           wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [31:0]           rd_data
);

    logic [31:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/pkt_mem_responder.sv
// Responder for the CPU packet-memory read port: holds one packet, hands it
// between writer and CPU, and serves unaligned word/half/byte reads in 1 cycle.
module pkt_mem_responder
    import pkt_mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  wr_ready,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [31:0]           wr_data,
    input  logic                  wr_done,
    input  logic [ADDR_WIDTH+2:0] wr_len,
    output logic                  pkt_ready,
    output logic [31:0]           packet_len,
    input  logic                  cpu_done,
    input  logic                  packet_rd_en,
    input  logic [31:0]           packet_addr,
    input  logic [1:0]            transfer_sz,
    output logic [31:0]           packet_data,
    output logic                  rd_valid,
    output logic                  rd_oob
);

    localparam int BANK_AW = ADDR_WIDTH - 1;
    localparam logic [ADDR_WIDTH+2:0] CAP_BYTES = {1'b1, {(ADDR_WIDTH+2){1'b0}}};

    buf_state_e            state;
    logic                  wr_accept;
    logic [ADDR_WIDTH-1:0] rd_word;
    logic [BANK_AW-1:0]    even_raddr;
    logic [BANK_AW-1:0]    odd_raddr;
    logic [31:0]           even_rdata;
    logic [31:0]           odd_rdata;
    logic [32:0]           req_end;
    logic                  req_oob;
    logic [ADDR_WIDTH+2:0] len_clamped;
    logic                  rd_sel;
    logic [1:0]            rd_off;
    logic [1:0]            rd_sz;
    logic [31:0]           lo_word;
    logic [31:0]           hi_word;
    logic [31:0]           window;

    assign wr_accept = wr_en && (state != ST_READY);

    // Word w and w+1 always live in opposite banks; the even index advances
    // when w is odd, wrapping at capacity (that word only feeds OOB reads).
    assign rd_word    = packet_addr[ADDR_WIDTH+1:2];
    assign odd_raddr  = rd_word[ADDR_WIDTH-1:1];
    assign even_raddr = rd_word[ADDR_WIDTH-1:1] + BANK_AW'(rd_word[0]);

    assign req_end     = {1'b0, packet_addr} + {30'd0, xfer_bytes(transfer_sz)};
    assign req_oob     = (transfer_sz == SZ_RSV) || (state != ST_READY)
                         || (req_end > {1'b0, packet_len});
    assign len_clamped = (wr_len > CAP_BYTES) ? CAP_BYTES : wr_len;

    pkt_bank_ram #(.ADDR_WIDTH(BANK_AW)) u_even_bank (
        .clk     (clk),
        .wr_en   (wr_accept && !wr_addr[0]),
        .wr_addr (wr_addr[ADDR_WIDTH-1:1]),
        .wr_data (wr_data),
        .rd_addr (even_raddr),
        .rd_data (even_rdata)
    );

    pkt_bank_ram #(.ADDR_WIDTH(BANK_AW)) u_odd_bank (
        .clk     (clk),
        .wr_en   (wr_accept && wr_addr[0]),
        .wr_addr (wr_addr[ADDR_WIDTH-1:1]),
        .wr_data (wr_data),
        .rd_addr (odd_raddr),
        .rd_data (odd_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_EMPTY;
            wr_ready   <= 1'b1;
            pkt_ready  <= 1'b0;
            packet_len <= '0;
            rd_valid   <= 1'b0;
            rd_oob     <= 1'b0;
            rd_sel     <= 1'b0;
            rd_off     <= 2'd0;
            rd_sz      <= SZ_W;
        end else begin
            rd_valid <= packet_rd_en;
            rd_oob   <= packet_rd_en && req_oob;
            rd_sel   <= rd_word[0];
            rd_off   <= packet_addr[1:0];
            rd_sz    <= transfer_sz;
            case (state)
                ST_EMPTY, ST_FILL: begin
                    if (wr_done) begin
                        state      <= ST_READY;
                        wr_ready   <= 1'b0;
                        pkt_ready  <= 1'b1;
                        packet_len <= 32'(len_clamped);
                    end else if (wr_en) begin
                        state <= ST_FILL;
                    end
                end
                ST_READY: begin
                    if (cpu_done) begin
                        state     <= ST_EMPTY;
                        wr_ready  <= 1'b1;
                        pkt_ready <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_EMPTY;
                    wr_ready  <= 1'b1;
                    pkt_ready <= 1'b0;
                end
            endcase
        end
    end

    // Big-endian byte funnel: the requested bytes start at the top of the window.
    always_comb begin
        lo_word     = rd_sel ? odd_rdata : even_rdata;
        hi_word     = rd_sel ? even_rdata : odd_rdata;
        window      = 32'(({lo_word, hi_word} << {rd_off, 3'b000}) >> 32);
        packet_data = '0;
        if (rd_valid && !rd_oob) begin
            case (rd_sz)
                SZ_W:    packet_data = window;
                SZ_H:    packet_data = {16'h0000, window[31:16]};
                SZ_B:    packet_data = {24'h000000, window[31:24]};
                default: packet_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_mem_responder.sv
// Randomized scoreboard bench for pkt_mem_responder against a byte-array
// model of the packet buffer.
module tb_pkt_mem_responder;

    localparam int AW  = 10;
    localparam int CAP = 4 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_ready;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [31:0]   wr_data = '0;
    logic          wr_done = 1'b0;
    logic [AW+2:0] wr_len = '0;
    logic          pkt_ready;
    logic [31:0]   packet_len;
    logic          cpu_done = 1'b0;
    logic          packet_rd_en = 1'b0;
    logic [31:0]   packet_addr = '0;
    logic [1:0]    transfer_sz = '0;
    logic [31:0]   packet_data;
    logic          rd_valid;
    logic          rd_oob;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  model_mem [CAP];
    bit          model_ready = 1'b0;
    int          model_len = 0;
    logic [32:0] exp_q [$];
    logic        req_seen = 1'b0;

    always #5 clk = ~clk;

    pkt_mem_responder #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_ready     (wr_ready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_done      (wr_done),
        .wr_len       (wr_len),
        .pkt_ready    (pkt_ready),
        .packet_len   (packet_len),
        .cpu_done     (cpu_done),
        .packet_rd_en (packet_rd_en),
        .packet_addr  (packet_addr),
        .transfer_sz  (transfer_sz),
        .packet_data  (packet_data),
        .rd_valid     (rd_valid),
        .rd_oob       (rd_oob)
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Expected read result straight from the byte image and the ownership rules.
    function automatic logic [32:0] model_read(input logic [31:0] addr, input logic [1:0] sz);
        int          n;
        logic [31:0] d;
        n = (sz == 2'd0) ? 4 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 1 : 0;
        d = '0;
        if (!model_ready || sz == 2'd3 || ({1'b0, addr} + 33'(n) > 33'(model_len))) begin
            return {1'b1, 32'h0};
        end
        for (int i = 0; i < n; i++) begin
            d = (d << 8) | {24'h0, model_mem[int'(addr) + i]};
        end
        return {1'b0, d};
    endfunction

    task automatic apply_stimulus(input logic r, input logic we, input logic [AW-1:0] wa,
                                  input logic [31:0] wd, input logic wdn, input logic [AW+2:0] wl,
                                  input logic cd, input logic re, input logic [31:0] ra,
                                  input logic [1:0] sz);
        rst = r; wr_en = we; wr_addr = wa; wr_data = wd; wr_done = wdn; wr_len = wl;
        cpu_done = cd; packet_rd_en = re; packet_addr = ra; transfer_sz = sz;
        if (r) begin
            model_ready = 1'b0;
            model_len   = 0;
        end else begin
            if (re) exp_q.push_back(model_read(ra, sz));
            if (we && !model_ready) begin
                for (int b = 0; b < 4; b++) model_mem[int'(wa) * 4 + b] = wd[31 - 8*b -: 8];
            end
            if (model_ready) begin
                if (cd) model_ready = 1'b0;
            end else if (wdn) begin
                model_ready = 1'b1;
                model_len   = (int'(wl) > CAP) ? CAP : int'(wl);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0; wr_en = 1'b0; wr_done = 1'b0; cpu_done = 1'b0; packet_rd_en = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [1:0] sz);
        apply_stimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1, a, sz);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic dn, input logic [AW+2:0] l);
        apply_stimulus(1'b0, 1'b1, a, d, dn, l, 1'b0, 1'b0, '0, 2'd0);
    endtask

    task automatic do_release();
        apply_stimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0, '0, 2'd0);
    endtask

    task automatic check_status(input string tag);
        check_output({tag, " wr_ready"},   32'(wr_ready),  32'(!model_ready));
        check_output({tag, " pkt_ready"},  32'(pkt_ready), 32'(model_ready));
        check_output({tag, " packet_len"}, packet_len,     32'(model_len));
    endtask

    task automatic finish_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    endtask

    always @(posedge clk) req_seen <= packet_rd_en && !rst;

    // Monitor: every sampled request must produce exactly one response next cycle.
    always @(negedge clk) begin
        logic [32:0] e;
        check_output("rd_valid", 32'(rd_valid), 32'(req_seen));
        if (rd_valid) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected response", 32'(rd_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_output("rd_oob", 32'(rd_oob), 32'(e[32]));
                check_output("packet_data", packet_data, e[31:0]);
            end
        end
    end

    initial begin
        int len, nwords, j, tmp;
        int order [$];
        logic [31:0] a;

        apply_stimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 2'd0);
        apply_stimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 2'd0);
        check_status("reset");
        check_output("reset packet_data", packet_data, 32'h0);
        check_output("reset rd_oob", 32'(rd_oob), 32'd0);

        do_read(32'd0, 2'd0);
        do_write(10'd0, 32'h11223344, 1'b0, '0);
        do_read(32'd0, 2'd2);
        do_write(10'd1, 32'h55667788, 1'b0, '0);
        apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1, 13'd8, 1'b0, 1'b0, '0, 2'd0);
        check_status("after fill");

        do_read(32'd0, 2'd0);
        do_read(32'd2, 2'd1);
        do_read(32'd5, 2'd2);
        do_read(32'd3, 2'd0);
        do_read(32'd5, 2'd0);
        do_read(32'd7, 2'd2);
        do_read(32'd8, 2'd2);
        do_read(32'd0, 2'd3);
        do_read(32'hFFFF_FFFF, 2'd0);

        do_write(10'd0, 32'hDEADBEEF, 1'b0, '0);
        apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1, 13'd4, 1'b0, 1'b0, '0, 2'd0);
        do_read(32'd0, 2'd0);
        apply_stimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b1, 32'd0, 2'd0);
        check_status("release with read");

        for (int w = 0; w < CAP / 4; w++) begin
            do_write(AW'(w), $urandom, (w == CAP / 4 - 1), 13'd5000);
        end
        check_status("clamped len");
        do_read(32'd4092, 2'd0);
        do_read(32'd4094, 2'd0);
        do_read(32'd4093, 2'd0);
        do_read(32'd4094, 2'd1);
        do_read(32'd4095, 2'd2);
        for (int k = 0; k < 300; k++) begin
            a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, CAP + 4));
            do_read(a, 2'($urandom_range(0, 3)));
        end
        do_release();

        for (int p = 0; p < 3; p++) begin
            len    = $urandom_range(1, 256);
            nwords = (len + 3) / 4;
            order.delete();
            for (int w = 0; w < nwords; w++) order.push_back(w);
            for (int w = nwords - 1; w > 0; w--) begin
                j = $urandom_range(0, w);
                tmp = order[w]; order[w] = order[j]; order[j] = tmp;
            end
            foreach (order[w]) do_write(AW'(order[w]), $urandom, 1'b0, '0);
            apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1, 13'(len), 1'b0, 1'b0, '0, 2'd0);
            check_status("random packet");
            for (int k = 0; k < 150; k++) begin
                do_read(32'($urandom_range(0, len + 4)), 2'($urandom_range(0, 3)));
            end
            do_release();
        end

        do_write(10'd3, 32'hA5A5A5A5, 1'b0, '0);
        apply_stimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 2'd0);
        check_status("reset in fill");
        do_write(10'd0, 32'hCAFEF00D, 1'b1, 13'd4);
        do_read(32'd0, 2'd0);
        apply_stimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1, 32'd0, 2'd0);
        check_status("reset in ready");

        repeat (3) @(posedge clk);
        check_output("scoreboard drained", 32'(exp_q.size()), 32'd0);
        finish_run();
    end

    initial begin
        #1_000_000;
        miscompares++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        finish_run();
    end

endmodule

// File: doc/pkt_mem_responder.md
Name: pkt_mem_responder

Overview:
- Responder end of the BPF CPU's packet-memory read interface. Serves packet_addr / packet_rd_en / transfer_sz requests and returns packet_data.
- Holds one packet in on-chip RAM. A packet writer fills the RAM, then hands ownership to the CPU. The CPU releases it when filtering is finished.
- Sits between the packet snooper/writer and bpfcpu; one instance per CPU core.

Parameters:
- ADDR_WIDTH, 10, word-address width; capacity = 2^ADDR_WIDTH 32-bit words (4 KiB default).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wr_ready  out  1  buffer accepts writes (state EMPTY or FILL)
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_WIDTH  word address
- wr_data  in  32  packet word, big-endian (byte 0 = bits 31:24)
- wr_done  in  1  packet complete pulse
- wr_len  in  ADDR_WIDTH+3  packet length in bytes, sampled with wr_done
- pkt_ready  out  1  packet owned by CPU (state READY)
- packet_len  out  32  current packet length in bytes, zero-extended
- cpu_done  in  1  CPU release pulse
- packet_rd_en  in  1  read request
- packet_addr  in  32  byte address
- transfer_sz  in  2  0 = word (4B), 1 = half (2B), 2 = byte (1B), 3 = reserved
- packet_data  out  32  read result, right-justified, zero-extended
- rd_valid  out  1  packet_data valid
- rd_oob  out  1  read was out of bounds / illegal

Behaviour:
- Reset: state EMPTY; wr_ready=1; pkt_ready=0; packet_len=0; packet_data=0; rd_valid=0; rd_oob=0. RAM contents are not cleared. Reset mid-fill or mid-read aborts the operation, with no rd_valid afterwards.
- States:
  - EMPTY: first wr_en -> FILL; wr_done -> READY.
  - FILL: wr_done -> READY.
  - READY: cpu_done -> EMPTY.
- Write acceptance: wr_en writes in EMPTY/FILL only; it is ignored in READY.
  - wr_en and wr_done in the same cycle: the write lands, then the state goes READY.
  - Out-of-order addresses are permitted.
- Length: on wr_done, packet_len <= min(wr_len, 4*2^ADDR_WIDTH). Held until the next wr_done or rst.
- Read latency: exactly 1 cycle. A request in cycle N gives rd_valid=1 in N+1 with packet_data/rd_oob; otherwise rd_valid=0. Back-to-back requests are served every cycle.
- Unaligned reads:
  - Any byte address is legal; a word/half may straddle two words.
  - RAM is split into even-word and odd-word banks. Both words (w, w+1) are read in one cycle and a byte-lane funnel shift selects the result.
  - Size field and addr[1:0] are registered alongside the RAM read.
- Bounds: nbytes = 4/2/1. OOB if (zero-extended 33-bit addr + nbytes) > packet_len, or transfer_sz == 3, or state != READY. When OOB: packet_data=0, rd_oob=1.
  - The 33-bit sum prevents wrap at 0xFFFFFFFF.
  - Bank index for w+1 wraps modulo capacity. A wrapped word is only ever used on an OOB path, so it is masked.
- rd_en and cpu_done in the same cycle: the read is evaluated against the pre-release state and served normally. The state goes EMPTY.
- cpu_done outside READY: ignored.
- wr_done in READY: ignored.

Decomposition:
- Shared package:
  - transfer_sz encodings: SZ_W=0, SZ_H=1, SZ_B=2.
  - State encodings: EMPTY, FILL, READY.
  - Byte-count function.
  - These are reused by bpfvm_ctrl.
- One sub-module, pkt_bank_ram: simple dual-port RAM with one write port and one registered read port, instantiated twice (even/odd banks) with ADDR_WIDTH-1 address bits.

Test Plan:
- Fill words 0x11223344, 0x55667788 at wr_addr 0,1; wr_done with wr_len=8. Word read at addr 0 -> 0x11223344; half at 2 -> 0x00003344; byte at 5 -> 0x00000066; rd_valid one cycle after each, rd_oob=0.
- Same packet, word read at addr 3 (straddle) -> 0x44556677. Word read at addr 5 -> rd_oob=1, data 0. Byte read at addr 7 -> 0x00000088. Byte read at addr 8 -> OOB.
- Read while EMPTY, or with transfer_sz=3 in READY -> rd_valid=1, rd_oob=1, data 0. packet_addr=0xFFFFFFFF word read with len=8 -> OOB (no wrap).
- wr_en during READY at addr 0 with 0xDEADBEEF -> ignored; the subsequent word read at 0 still returns 0x11223344. cpu_done together with rd_en -> valid data returned, then wr_ready=1 and pkt_ready=0 next cycle.
- wr_done with wr_len=5000 at ADDR_WIDTH=10 -> packet_len=4096. wr_en+wr_done in the same cycle -> the write is visible on the first read.
- rst asserted in FILL and in READY with a read in flight -> next cycle: EMPTY, rd_valid=0, packet_len=0, wr_ready=1.
